// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Used by the priority/run-counter sub-module and the arbiter top.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DM   = 2'd2
    } arb_owner_t;

    localparam int MAX_DM_RUN_W = 4;

    // Saturating increment for the data-port run counter.
    function automatic logic [MAX_DM_RUN_W-1:0] sat_inc(
        input logic [MAX_DM_RUN_W-1:0] value,
        input logic [MAX_DM_RUN_W-1:0] limit
    );
        logic [MAX_DM_RUN_W-1:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + {{(MAX_DM_RUN_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Fixed data-port priority with a starvation guard: once the data port has
// won MAX_DM_RUN grants in a row against a pending fetch, fetch wins next.
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_DM_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic arb_en,
    input  logic if_elig,
    input  logic dm_elig,
    input  logic if_req,
    output logic grant_if,
    output logic grant_dm
);

    localparam logic [MAX_DM_RUN_W-1:0] RUN_MAX = MAX_DM_RUN_W'(MAX_DM_RUN);

    logic [MAX_DM_RUN_W-1:0] run_cnt_r;
    logic                    guard_s;

    // Select the winner; fetch only beats the data port once the run limit is hit.
    always_comb begin
        guard_s  = (run_cnt_r == RUN_MAX);
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (arb_en) begin
            grant_if = if_elig & (~dm_elig | guard_s);
            grant_dm = dm_elig & ~(if_elig & guard_s);
        end else begin
            grant_if = 1'b0;
            grant_dm = 1'b0;
        end
    end

    // Count consecutive data grants that were made while fetch was waiting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run_cnt_r <= {MAX_DM_RUN_W{1'b0}};
        end else if (grant_if) begin
            run_cnt_r <= {MAX_DM_RUN_W{1'b0}};
        end else if (grant_dm) begin
            if (if_req) begin
                run_cnt_r <= sat_inc(run_cnt_r, RUN_MAX);
            end else begin
                run_cnt_r <= {MAX_DM_RUN_W{1'b0}};
            end
        end else begin
            run_cnt_r <= run_cnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port, variable-latency memory between fetch and the data
// stage; one transaction outstanding at a time, acks and read data registered.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_DM_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ack,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          stall_if,
    output logic          stall_dm
);

    arb_state_t state_r, state_s;
    arb_owner_t owner_r;

    logic          mem_req_r, mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic          if_ack_r, dm_ack_r;
    logic [DW-1:0] if_rdata_r, dm_rdata_r;
    logic          grant_if_s, grant_dm_s;
    logic          if_elig_s, dm_elig_s;

    // A requester whose ack is pulsing still holds req for its next access.
    assign if_elig_s = if_req & ~if_ack_r;
    assign dm_elig_s = dm_req & ~dm_ack_r;

    mem_arb_prio #(
        .MAX_DM_RUN (MAX_DM_RUN)
    ) u_prio (
        .clk      (clk),
        .rst      (rst),
        .arb_en   (state_r == IDLE),
        .if_elig  (if_elig_s),
        .dm_elig  (dm_elig_s),
        .if_req   (if_req),
        .grant_if (grant_if_s),
        .grant_dm (grant_dm_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_if_s || grant_dm_s) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    state_s = mem_we_r ? IDLE : RESP;
                end else begin
                    state_s = REQ;
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Request, response and ack datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_r     <= NONE;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            if_ack_r    <= 1'b0;
            dm_ack_r    <= 1'b0;
            if_rdata_r  <= {DW{1'b0}};
            dm_rdata_r  <= {DW{1'b0}};
        end else begin
            if_ack_r <= 1'b0;
            dm_ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_dm_s) begin
                        owner_r     <= DM;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= dm_we;
                        mem_addr_r  <= dm_addr;
                        mem_wdata_r <= dm_wdata;
                    end else if (grant_if_s) begin
                        owner_r     <= IF;
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= 1'b0;
                        mem_addr_r  <= if_addr;
                        mem_wdata_r <= {DW{1'b0}};
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        mem_req_r <= 1'b0;
                        if (mem_we_r) begin
                            dm_ack_r <= 1'b1;
                            owner_r  <= NONE;
                        end
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        owner_r <= NONE;
                        if (owner_r == IF) begin
                            if_rdata_r <= mem_rdata;
                            if_ack_r   <= 1'b1;
                        end else if (owner_r == DM) begin
                            dm_rdata_r <= mem_rdata;
                            dm_ack_r   <= 1'b1;
                        end
                    end
                end
                default: begin
                    mem_req_r <= 1'b0;
                    owner_r   <= NONE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_ack    = if_ack_r;
    assign dm_ack    = dm_ack_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign stall_if  = if_req & ~if_ack_r;
    assign stall_dm  = dm_req & ~dm_ack_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter; the bench plays the memory by
// driving mem_gnt / mem_rvalid cycle by cycle.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata;
    logic        if_ack, dm_ack;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_dm;

    int vectors = 0;
    int errs    = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_DM_RUN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_rdata   (dm_rdata),
        .dm_ack     (dm_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall_if   (stall_if),
        .stall_dm   (stall_dm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b1; if_addr = 32'h0000_0040;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_0001;

        // Reset held for 3 cycles with traffic on the inputs.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        end
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_dm_rdata", dm_rdata, 32'd0);
        mem_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rel_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rel_mem_addr", mem_addr, 32'h0000_0040);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0011;
        tick();
        chk("rel_if_ack", {31'd0, if_ack}, 32'd1);
        chk("rel_if_rdata", if_rdata, 32'h0000_0011);
        if_req = 1'b0; mem_rvalid = 1'b0;
        tick();

        // Single fetch: t = this cycle.
        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1 chk("sf_stall_t", {31'd0, stall_if}, 32'd1);
        tick();
        chk("sf_mem_req_t1", {31'd0, mem_req}, 32'd1);
        chk("sf_mem_addr", mem_addr, 32'h0000_0010);
        chk("sf_mem_we", {31'd0, mem_we}, 32'd0);
        chk("sf_stall_t1", {31'd0, stall_if}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093;
        chk("sf_mem_req_t2", {31'd0, mem_req}, 32'd0);
        chk("sf_ack_t2", {31'd0, if_ack}, 32'd0);
        chk("sf_stall_t2", {31'd0, stall_if}, 32'd1);
        tick();
        chk("sf_ack_t3", {31'd0, if_ack}, 32'd1);
        chk("sf_rdata", if_rdata, 32'h0050_0093);
        chk("sf_stall_t3", {31'd0, stall_if}, 32'd0);
        if_req = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF_FFFF;
        tick();
        chk("sf_ack_t4", {31'd0, if_ack}, 32'd0);
        chk("sf_rdata_hold", if_rdata, 32'h0050_0093);

        // Simultaneous fetch and load: data first, fetch granted in dm_ack cycle.
        if_req = 1'b1; if_addr = 32'h0000_0000;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100;
        tick();
        chk("sim_dm_first", mem_addr, 32'h0000_0100);
        chk("sim_mem_req", {31'd0, mem_req}, 32'd1);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
        tick();
        chk("sim_dm_ack", {31'd0, dm_ack}, 32'd1);
        chk("sim_dm_rdata", dm_rdata, 32'hAAAA_5555);
        dm_req = 1'b0; mem_rvalid = 1'b0;
        #1 chk("sim_stalls", {30'd0, stall_if, stall_dm}, 32'd2);
        tick();
        chk("sim_if_nobubble", {31'd0, mem_req}, 32'd1);
        chk("sim_if_addr", mem_addr, 32'h0000_0000);
        chk("sim_dm_ack_off", {31'd0, dm_ack}, 32'd0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        tick();
        chk("sim_if_rdata", if_rdata, 32'h0000_0013);
        if_req = 1'b0; mem_rvalid = 1'b0;
        tick();

        // Store with grant withheld for 3 cycles.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0200; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            tick();
            dm_req = 1'b0;
            chk("st_hold", {mem_req, mem_we, mem_addr[29:0]}, {2'b11, 30'h0000_0200});
            chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        chk("st_dm_ack", {31'd0, dm_ack}, 32'd1);
        chk("st_mem_req_off", {31'd0, mem_req}, 32'd0);
        if_req = 1'b1; if_addr = 32'h0000_0300;
        tick();
        chk("st_no_resp", {31'd0, mem_req}, 32'd1);
        chk("st_next_addr", mem_addr, 32'h0000_0300);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        tick();
        chk("st_if_ack", {31'd0, if_ack}, 32'd1);
        if_req = 1'b0; mem_rvalid = 1'b0;
        tick();

        // Starvation guard: fetch pending at every arbitration point.
        if_addr = 32'h0000_0500; dm_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h0000_0400 + 32'(k * 4);
            tick();
            chk("sv_dm_grant", mem_addr, 32'h0000_0400 + 32'(k * 4));
            if_req = 1'b0; mem_gnt = 1'b1;
            tick();
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_1000 + 32'(k);
            tick();
            chk("sv_dm_ack", {31'd0, dm_ack}, 32'd1);
            mem_rvalid = 1'b0;
            tick();
            chk("sv_idle_gap", {31'd0, mem_req}, 32'd0);
        end
        if_req = 1'b1; dm_addr = 32'h0000_0410;
        tick();
        chk("sv_if_forced", mem_addr, 32'h0000_0500);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0099;
        tick();
        chk("sv_if_rdata", if_rdata, 32'h0000_0099);
        if_req = 1'b0; mem_rvalid = 1'b0;
        tick();
        chk("sv_dm_resumes", {mem_req, mem_addr[30:0]}, {1'b1, 31'h0000_0410});
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0088;
        tick();
        chk("sv_dm_rdata", dm_rdata, 32'h0000_0088);
        dm_req = 1'b0; mem_rvalid = 1'b0;
        tick();

        // Reset during RESP abandons the load.
        rst = 1'b0;
        tick();
        rst = 1'b1;
        dm_req = 1'b1; dm_addr = 32'h0000_0600;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0; dm_req = 1'b0;
        chk("mr_in_resp", {31'd0, mem_req}, 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
        tick();
        mem_rvalid = 1'b0;
        chk("mr_no_ack", {30'd0, if_ack, dm_ack}, 32'd0);
        tick();
        chk("mr_no_ack2", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("mr_dm_rdata", dm_rdata, 32'd0);
        chk("mr_if_rdata", if_rdata, 32'd0);
        chk("mr_mem_req", {31'd0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency unified memory between the fetch stage (instruction reads) and the memory stage (loads/stores) of the 5-stage pipeline.
- Sequences each access through a request/grant/response handshake toward memory.
- Returns acks and read data to the winning stage and drives per-stage stall signals to the hazard logic.
- Data port has priority; a starvation guard bounds how long fetch can be locked out.

Parameters:
- AW, 32, address width (byte address).
- DW, 32, data width.
- MAX_DM_RUN, 4, max consecutive data-port grants while if_req is pending before fetch is forced to win; range 1..15.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-low reset
- if_req  input  1  fetch read request; held high until if_ack
- if_addr  input  AW  fetch address; stable while if_req high
- if_rdata  output  DW  instruction word; valid in if_ack cycle, held until next if_ack
- if_ack  output  1  one-cycle completion pulse to fetch
- dm_req  input  1  data request; held high until dm_ack
- dm_we  input  1  1 = store, 0 = load
- dm_addr  input  AW  data address
- dm_wdata  input  DW  store data
- dm_rdata  output  DW  load data; valid in dm_ack cycle, held until next dm_ack
- dm_ack  output  1  one-cycle completion pulse to memory stage
- mem_req  output  1  request to memory; held until mem_gnt
- mem_we  output  1  write enable toward memory
- mem_addr  output  AW  address toward memory
- mem_wdata  output  DW  write data toward memory
- mem_gnt  input  1  memory accepted the request this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  DW  read data
- stall_if  output  1  if_req & ~if_ack
- stall_dm  output  1  dm_req & ~dm_ack

Behaviour:
- Reset (rst == 0 at a clk edge):
  - State goes to IDLE; owner is NONE; run counter is 0.
  - mem_req, mem_we, if_ack, dm_ack are 0; mem_addr, mem_wdata, if_rdata, dm_rdata are 0.
  - Reset mid-transaction abandons the transaction. A mem_rvalid arriving later is ignored because it occurs in IDLE.
- States: IDLE, REQ, RESP.
- IDLE: arbitrate among eligible requesters.
  - A requester whose ack is high this cycle is not eligible.
  - Both eligible: dm wins unless run_cnt == MAX_DM_RUN, in which case if wins.
  - Winner's addr/we/wdata are registered into the mem_* outputs; mem_req = 1 next cycle; go to REQ; owner is recorded.
  - Fetch always drives mem_we = 0.
- REQ: hold mem_* stable until mem_gnt = 1.
  - On gnt with a write: clear mem_req, pulse dm_ack next cycle, go to IDLE.
  - On gnt with a read: clear mem_req, go to RESP.
- RESP: wait for mem_rvalid.
  - On rvalid: capture mem_rdata into the owner's rdata register, pulse the owner's ack next cycle, go to IDLE.
  - mem_rvalid in IDLE or REQ is ignored.
- Run counter:
  - Increments (saturating at MAX_DM_RUN) on each dm grant made while if_req is high.
  - Clears on any if grant, and on a dm grant made while if_req is low.
- Latency:
  - Read with gnt in first REQ cycle and rvalid one cycle later: req seen at t, mem_req at t+1, rvalid at t+2, ack at t+3.
  - Write: ack at t+2 when gnt is at t+1.
- Back-to-back: the cycle in which ack pulses is an IDLE cycle. The other requester can be granted in that same cycle, giving mem_req again the next cycle with no bubble.
- Only one transaction is outstanding at a time; no pipelining toward memory.
- stall_if and stall_dm are combinational from inputs and the registered acks.
- Protocol violation: if the requester drops req before its ack, the transaction still completes and the ack still pulses; the pipeline must tolerate this.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, REQ, RESP), owner enum (NONE, IF, DM), MAX_DM_RUN_W = 4 counter width constant.
- Sub-module mem_arb_prio: combinational priority select plus the sequential saturating run counter. It outputs grant_if and grant_dm; the top holds the FSM and datapath registers.

Test Plan:
- Reset: hold rst = 0 for 3 cycles with if_req = 1 and mem_rvalid = 1 → all outputs 0, mem_req stays 0. Release rst → mem_req = 1 one cycle later with mem_addr = if_addr.
- Single fetch: if_addr = 0x0000_0010, gnt at first REQ cycle, rvalid + rdata = 0x0050_0093 one cycle later → if_ack at t+3, if_rdata = 0x0050_0093, stall_if high t..t+2.
- Simultaneous requests: if_req and dm_req (load 0x100) rise at t → dm is served first. if is granted in the dm_ack cycle; mem_req for 0x0 follows the next cycle with no bubble.
- Store: dm_we = 1, addr = 0x200, wdata = 0xDEAD_BEEF, gnt delayed 3 cycles → mem_req/addr/wdata stable for 4 cycles. dm_ack arrives one cycle after gnt, and no RESP state is entered.
- Starvation with MAX_DM_RUN = 4: dm_req held continuously with back-to-back loads, if_req high → exactly 4 dm grants, then 1 if grant, then dm resumes.
- Reset mid-read: assert rst while in RESP, release it, then drive mem_rvalid with 0x1234 → no ack, rdata registers remain 0.
